// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - MIPS pipeline hazard/forwarding controller with MEM-stage access sequencer (optional PIPE_PERF_CNT_EN)
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_rs,
  input  logic [4:0] EX_rt,
  input  logic       EX_RegWrite,
  input  logic       EX_MemToReg,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_BranchTaken,
  input  logic       MEM_RegWrite,
  input  logic       MEM_MemToReg,
  input  logic       MEM_MemWrite,
  input  logic [4:0] MEM_WriteReg,
  input  logic [4:0] WB_WriteReg,
  input  logic       WB_RegWrite,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       dmem_timeout,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       ID_EX_Stall,
  output logic       EX_MEM_Stall,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       MEM_WB_Flush,
  output logic [1:0] Forward_A,
  output logic [1:0] Forward_B
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_TIMED_OUT = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic [7:0] w_wait_cnt_inc;
  logic       r_timeout;
  logic       w_set_timeout;

  logic       w_acc;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_lu_stall;
  logic       w_br_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_acc          = MEM_MemToReg | MEM_MemWrite;
  assign w_mem_stall    = w_acc & ~dmem_ready & (r_state != ST_TIMED_OUT);
  assign w_wait_cnt_inc = r_wait_cnt + 8'd1;
  assign dmem_timeout   = r_timeout;

  // Hazard detection; a taken branch squashes the instruction a load-use stall would hold
  always_comb begin
    w_load_use = EX_MemToReg & EX_RegWrite & (EX_WriteReg != 5'd0) &
                 ((EX_WriteReg == ID_rs) | (ID_UsesRt & (EX_WriteReg == ID_rt)));
    w_br_flush = EX_BranchTaken & ~w_mem_stall;
    w_lu_stall = w_load_use & ~w_mem_stall & ~EX_BranchTaken;
  end

  // Operand forwarding: the younger MEM-stage ALU result beats the WB-stage value
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (MEM_RegWrite & ~MEM_MemToReg & (MEM_WriteReg != 5'd0) & (MEM_WriteReg == EX_rs)) begin
      w_fwd_a = 2'b10;
    end else if (WB_RegWrite & (WB_WriteReg != 5'd0) & (WB_WriteReg == EX_rs)) begin
      w_fwd_a = 2'b01;
    end
    if (MEM_RegWrite & ~MEM_MemToReg & (MEM_WriteReg != 5'd0) & (MEM_WriteReg == EX_rt)) begin
      w_fwd_b = 2'b10;
    end else if (WB_RegWrite & (WB_WriteReg != 5'd0) & (WB_WriteReg == EX_rt)) begin
      w_fwd_b = 2'b01;
    end
  end

  // Memory sequencer next state: count wait cycles, give up after MAX_WAIT stalls
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_set_timeout   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_acc & ~dmem_ready) begin
          w_wait_cnt_next = 8'd1;
          if (LP_MAX_WAIT <= 8'd1) begin
            w_state_next  = ST_TIMED_OUT;
            w_set_timeout = 1'b1;
          end else begin
            w_state_next = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_next    = ST_RUN;
          w_wait_cnt_next = 8'd0;
        end else begin
          w_wait_cnt_next = w_wait_cnt_inc;
          if (w_wait_cnt_inc >= LP_MAX_WAIT) begin
            w_state_next  = ST_TIMED_OUT;
            w_set_timeout = 1'b1;
          end
        end
      end
      ST_TIMED_OUT: begin
        w_state_next    = ST_RUN;
        w_wait_cnt_next = 8'd0;
      end
      default: begin
        w_state_next    = ST_RUN;
        w_wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Sequencer state, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Pipeline controls; reset forces bubbles everywhere and no stalls
  always_comb begin
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    ID_EX_Stall  = 1'b0;
    EX_MEM_Stall = 1'b0;
    IF_ID_Flush  = 1'b1;
    ID_EX_Flush  = 1'b1;
    MEM_WB_Flush = 1'b1;
    dmem_req     = 1'b0;
    Forward_A    = 2'b00;
    Forward_B    = 2'b00;
    if (!reset) begin
      PC_Stall     = w_mem_stall | w_lu_stall;
      IF_ID_Stall  = w_mem_stall | w_lu_stall;
      ID_EX_Stall  = w_mem_stall;
      EX_MEM_Stall = w_mem_stall;
      IF_ID_Flush  = w_br_flush;
      ID_EX_Flush  = w_br_flush | w_lu_stall;
      MEM_WB_Flush = w_mem_stall;
      dmem_req     = w_acc & (r_state != ST_TIMED_OUT);
      Forward_A    = w_fwd_a;
      Forward_B    = w_fwd_b;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Wrapping event counters for stall/flush profiling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_stall  <= 32'd0;
      perf_mem_stall <= 32'd0;
      perf_flush     <= 32'd0;
    end else begin
      if (w_lu_stall) begin
        perf_lu_stall <= perf_lu_stall + 32'd1;
      end
      if (w_mem_stall) begin
        perf_mem_stall <= perf_mem_stall + 32'd1;
      end
      if (w_br_flush) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int MW = 4;

  logic       clk;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
  logic       ID_UsesRt, EX_RegWrite, EX_MemToReg, EX_BranchTaken;
  logic       MEM_RegWrite, MEM_MemToReg, MEM_MemWrite, WB_RegWrite, dmem_ready;
  logic       dmem_req, dmem_timeout, PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall;
  logic       IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush;
  logic [1:0] Forward_A, Forward_B;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_lu_stall, perf_mem_stall, perf_flush;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the access sequencer: stalled cycles of the current access
  int   waited;
  bit   to_pend;
  bit   sticky;
  logic last_mstall;
  logic s_pc, s_req, s_iff, s_idf;
  int   cnt_a, cnt_b, cnt_c;

  pipe_hazard_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_MemWrite(MEM_MemWrite),
    .MEM_WriteReg(MEM_WriteReg), .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_timeout(dmem_timeout),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
    .EX_MEM_Stall(EX_MEM_Stall), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MEM_WB_Flush(MEM_WB_Flush), .Forward_A(Forward_A), .Forward_B(Forward_B)
`ifdef PIPE_PERF_CNT_EN
    , .perf_lu_stall(perf_lu_stall), .perf_mem_stall(perf_mem_stall), .perf_flush(perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (MEM_RegWrite && !MEM_MemToReg && MEM_WriteReg == src) return 2'b10;
    if (WB_RegWrite && WB_WriteReg == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] obs_vec();
    return {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush,
            MEM_WB_Flush, dmem_req, dmem_timeout, Forward_A, Forward_B};
  endfunction

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; ID_UsesRt = 0; EX_rs = 0; EX_rt = 0;
    EX_RegWrite = 0; EX_MemToReg = 0; EX_WriteReg = 0; EX_BranchTaken = 0;
    MEM_RegWrite = 0; MEM_MemToReg = 0; MEM_MemWrite = 0; MEM_WriteReg = 0;
    WB_WriteReg = 0; WB_RegWrite = 0; dmem_ready = 0;
  endtask

  // inputs are set by the caller just after a rising edge; check mid-cycle, then advance
  task automatic step(input string tag);
    logic acc, ms, lu, br, lus;
    logic [12:0] e;
    #2;
    acc = MEM_MemToReg | MEM_MemWrite;
    ms  = acc && !dmem_ready && !to_pend;
    lu  = EX_MemToReg && EX_RegWrite && EX_WriteReg != 0 &&
          (EX_WriteReg == ID_rs || (ID_UsesRt && EX_WriteReg == ID_rt));
    br  = EX_BranchTaken && !ms;
    lus = lu && !ms && !EX_BranchTaken;
    e = {ms | lus, ms | lus, ms, ms, br, br | lus, ms, acc & !to_pend, sticky,
         fwd(EX_rs), fwd(EX_rt)};
    chk(tag, {3'b0, obs_vec()}, {3'b0, e});
    s_pc = PC_Stall; s_req = dmem_req; s_iff = IF_ID_Flush; s_idf = ID_EX_Flush;
    last_mstall = ms;
    @(posedge clk);
    if (ms) begin
      waited++;
      if (waited >= MW) begin
        to_pend = 1; sticky = 1; waited = 0;
      end
    end else begin
      waited = 0; to_pend = 0;
    end
    #1;
  endtask

  initial begin
    waited = 0; to_pend = 0; sticky = 0; last_mstall = 0;
    clear_inputs();
    reset = 1'b1;
    #3;
    chk("reset_vals", {3'b0, obs_vec()}, 16'b000_0000111000000);
    @(posedge clk); #1;
    reset = 1'b0;
    step("idle");

    // load-use: lw $t0 in EX, ID reads $t0
    EX_MemToReg = 1; EX_RegWrite = 1; EX_WriteReg = 8; ID_rs = 8;
    step("lu_hit");
    chk("lu_pc", {15'b0, s_pc}, 16'd1);
    chk("lu_idf", {15'b0, s_idf}, 16'd1);
    EX_MemToReg = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    step("lu_bubble");
    chk("lu_one_cycle", {15'b0, s_pc}, 16'd0);
    EX_MemToReg = 1; EX_RegWrite = 1; EX_WriteReg = 0; ID_rs = 0;
    step("lu_r0");
    chk("lu_r0_pc", {15'b0, s_pc}, 16'd0);
    ID_UsesRt = 1; ID_rt = 9; EX_WriteReg = 9; ID_rs = 3;
    step("lu_rt");
    clear_inputs();

    // forwarding priority
    MEM_RegWrite = 1; MEM_WriteReg = 5; WB_RegWrite = 1; WB_WriteReg = 5; EX_rs = 5; EX_rt = 5;
    step("fwd_mem");
    chk("fwd_a_mem", {14'b0, Forward_A}, 16'd2);
    MEM_RegWrite = 0;
    step("fwd_wb");
    chk("fwd_a_wb", {14'b0, Forward_A}, 16'd1);
    WB_RegWrite = 0;
    step("fwd_none");
    MEM_RegWrite = 1; MEM_MemToReg = 1; dmem_ready = 1; WB_RegWrite = 1; EX_rt = 0;
    step("fwd_load_in_mem");
    clear_inputs();

    // store with three wait cycles
    MEM_MemWrite = 1; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      step("mem_wait");
      cnt_a += int'(s_pc); cnt_b += int'(s_req);
    end
    chk("mw_stall_cycles", 16'(cnt_a), 16'd3);
    chk("mw_req_cycles", 16'(cnt_b), 16'd4);
    clear_inputs();
    step("mw_done");

    // timeout: ready never arrives
    MEM_MemToReg = 1; MEM_RegWrite = 1; MEM_WriteReg = 7; cnt_a = 0;
    for (int i = 0; i < MW + 1; i++) begin
      step("timeout_seq");
      cnt_a += int'(s_pc);
    end
    chk("to_stall_cycles", 16'(cnt_a), 16'(MW));
    chk("to_flag", {15'b0, dmem_timeout}, 16'd1);
    clear_inputs();
    step("to_after");
    chk("to_sticky", {15'b0, dmem_timeout}, 16'd1);

    // branch held during a 2-cycle wait, flush on release
    MEM_MemWrite = 1; EX_BranchTaken = 1; cnt_c = 0;
    for (int i = 0; i < 2; i++) begin
      step("br_in_wait");
      cnt_c += int'(s_iff) + int'(s_idf);
    end
    chk("br_no_flush_stalled", 16'(cnt_c), 16'd0);
    dmem_ready = 1;
    step("br_release");
    chk("br_flush_release", {14'b0, s_iff, s_idf}, 16'd3);
    clear_inputs();

    // branch together with load-use
    EX_BranchTaken = 1; EX_MemToReg = 1; EX_RegWrite = 1; EX_WriteReg = 4; ID_rs = 4;
    step("br_lu");
    chk("br_lu_pc", {15'b0, s_pc}, 16'd0);
    clear_inputs();

    // randomized traffic; MEM-stage controls frozen while the model says stalled
    for (int i = 0; i < 400; i++) begin
      ID_rs = 5'($urandom_range(0, 3)); ID_rt = 5'($urandom_range(0, 3));
      ID_UsesRt = 1'($urandom); EX_rs = 5'($urandom_range(0, 3)); EX_rt = 5'($urandom_range(0, 3));
      EX_RegWrite = 1'($urandom); EX_MemToReg = 1'($urandom);
      EX_WriteReg = 5'($urandom_range(0, 3)); EX_BranchTaken = ($urandom_range(0, 4) == 0);
      MEM_WriteReg = 5'($urandom_range(0, 3)); WB_WriteReg = 5'($urandom_range(0, 3));
      WB_RegWrite = 1'($urandom);
      if (!last_mstall) begin
        MEM_RegWrite = 1'($urandom); MEM_MemToReg = 1'($urandom);
        MEM_MemWrite = ($urandom_range(0, 2) == 0);
      end
      dmem_ready = ($urandom_range(0, 3) == 0);
      step("random");
    end
    clear_inputs();
    step("rand_end");

    // asynchronous reset in the middle of a wait
    MEM_MemWrite = 1;
    step("pre_rst_wait");
    step("pre_rst_wait");
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_vals", {3'b0, obs_vec()}, 16'b000_0000111000000);
    waited = 0; to_pend = 0; sticky = 0;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    chk("perf_lu_zero", perf_lu_stall[15:0], 16'd0);
    chk("perf_mem_zero", perf_mem_stall[15:0], 16'd0);
    chk("perf_flush_zero", perf_flush[15:0], 16'd0);
`endif
    clear_inputs();
    step("post_rst_idle");
    MEM_MemWrite = 1;
    step("post_rst_stall");
    chk("post_rst_stall_pc", {15'b0, s_pc}, 16'd1);
    dmem_ready = 1;
    step("post_rst_ready");
    clear_inputs();
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. It drives stall/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and selects the EX-stage operand forwarding paths. It sequences data-memory accesses made from the MEM stage through a request/ready handshake, freezing the pipeline during wait states. It sits beside the pipeline registers and sees only their control/tag fields, never data.

## Interface
- MAX_WAIT, 16: memory wait cycles allowed before timeout (1..255).
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- ID_rs, ID_rt  in  5  source registers of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- EX_rs, EX_rt  in  5  source registers of the instruction in EX.
- EX_RegWrite, EX_MemToReg  in  1  EX-stage controls.
- EX_WriteReg  in  5  EX destination register.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- MEM_RegWrite, MEM_MemToReg, MEM_MemWrite  in  1  MEM-stage controls; MEM_RegWrite is already MOVZ-gated.
- MEM_WriteReg, WB_WriteReg  in  5  destinations.
- WB_RegWrite  in  1  WB write enable.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  MEM-stage access pending.
- dmem_timeout  out  1  sticky timeout flag.
- PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall  out  1  hold register contents.
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1  load a bubble (controls cleared).
- Forward_A, Forward_B  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM ALU result.

## Operation
- Memory access `acc = MEM_MemToReg | MEM_MemWrite`. `dmem_req = acc & (state != TIMED_OUT)`.
- States: RUN, MEM_WAIT, TIMED_OUT. Register: 8-bit `wait_cnt`.
- RUN: if `acc & !dmem_ready`, go to MEM_WAIT with `wait_cnt = 1`. Otherwise stay in RUN; a zero-wait access completes with no stall.
- MEM_WAIT: `dmem_ready` returns to RUN. Otherwise `wait_cnt++`; when `wait_cnt == MAX_WAIT`, go to TIMED_OUT and set dmem_timeout.
- TIMED_OUT: lasts one cycle, treats the access as complete (load data undefined), then returns to RUN. dmem_timeout stays 1 until reset.
- `mem_stall = acc & !dmem_ready & (state != TIMED_OUT)`. It asserts PC, IF_ID, ID_EX and EX_MEM stall plus MEM_WB_Flush, and suppresses all other flushes.
- Load-use: `EX_MemToReg & EX_RegWrite & EX_WriteReg != 0 & (EX_WriteReg == ID_rs | (ID_UsesRt & EX_WriteReg == ID_rt))`. When active and `!mem_stall`, it asserts PC_Stall, IF_ID_Stall and ID_EX_Flush for one cycle.
- Branch: `EX_BranchTaken & !mem_stall` asserts IF_ID_Flush and ID_EX_Flush, and overrides load-use (the stalled instruction is squashed anyway).
- Forwarding for Forward_A (rs) and Forward_B (rt), in priority order:
  - 10 if `MEM_RegWrite & !MEM_MemToReg & MEM_WriteReg != 0 & MEM_WriteReg == src`.
  - else 01 if `WB_RegWrite & WB_WriteReg != 0 & WB_WriteReg == src`.
  - else 00.
- Forwarding is combinational and is evaluated during stalls too.
- Priority: mem_stall > branch flush > load-use.

## Timing
- All control outputs are combinational from the inputs and the registered state, so they are valid in the same cycle the hazard is presented.
- A load-use hazard costs one bubble. A branch costs two squashed instructions.
- A memory access with N wait cycles costs N stall cycles. Timeout costs MAX_WAIT + 1 cycles.
- Reset (asynchronous, including mid-wait): state = RUN, wait_cnt = 0, dmem_timeout = 0. While reset is high, all stalls = 0, all flushes = 1, dmem_req = 0, Forward_A/B = 00.
- A branch in EX during mem_stall is held (EX_MEM frozen) and its flush takes effect in the first cycle after the stall releases.
- dmem_ready with `acc = 0` is ignored.

## Configuration
- `PIPE_PERF_CNT_EN` defined: adds three 32-bit wrapping output counters, each cleared by reset:
  - `perf_lu_stall`: load-use stall cycles.
  - `perf_mem_stall`: mem_stall cycles.
  - `perf_flush`: branch flush events.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Load-use: `lw $t0` in EX (EX_WriteReg = 8), ID_rs = 8 -> PC_Stall = IF_ID_Stall = ID_EX_Flush = 1 for exactly one cycle. The same case with EX_WriteReg = 0 -> no stall.
- Forwarding: MEM_WriteReg = 5 (ALU) and WB_WriteReg = 5, EX_rs = 5 -> Forward_A = 10. Clear MEM_RegWrite -> Forward_A = 01. A MOVZ-suppressed write (MEM_RegWrite = 0) -> 01 or 00.
- Memory wait: sw in MEM, dmem_ready low for 3 cycles -> four-way stall + MEM_WB_Flush for 3 cycles, dmem_req high for 4 cycles, release on the ready cycle.
- Timeout with MAX_WAIT = 4, ready never asserted -> 4 stall cycles, TIMED_OUT for one cycle with stalls = 0, dmem_timeout = 1 and held.
- Branch taken during a 2-cycle memory wait -> no flush while stalled; IF_ID_Flush = ID_EX_Flush = 1 on the cycle after release. Branch together with load-use -> flushes only, PC_Stall = 0.
- Reset asserted asynchronously mid-MEM_WAIT -> outputs immediately take reset values; after release state = RUN and the counters (if enabled) = 0.
